clk_div_bank: RTL and testbench

Multi-channel programmable clock divider for the conv-tree serializer clock tree. It generates NUM_CH independent divided clocks from one source clock, each with a runtime-programmable divisor, a per-channel enable and a one-cycle period tick. Divisor changes are double-buffered and take effect only at a period boundary, so output clocks never glitch. A global sync input phase-aligns all channels.

---
 rtl/clk_div_bank.sv | 130 +++++++++++++
 tb/tb_clk_div_bank.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/clk_div_bank.sv
// rtl/clk_div_bank.sv - multi-channel glitch-free programmable clock divider
// Divisor writes are double-buffered per channel and only land at a period boundary.
module clk_div_bank #(
  parameter int NUM_CH      = 4,
  parameter int CNT_W       = 10,
  parameter int DEFAULT_DIV = 2,
  localparam int CH_W       = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [NUM_CH-1:0] en_i,
  input  logic              sync_i,
  input  logic              cfg_valid_i,
  input  logic [CH_W-1:0]   cfg_chan_i,
  input  logic [CNT_W-1:0]  cfg_div_i,
  output logic              cfg_ready_o,
  output logic [NUM_CH-1:0] clk_o,
  output logic [NUM_CH-1:0] tick_o
);

  typedef enum logic {IDLE, RUN} state_e;

  logic [NUM_CH-1:0] pend_vec;

  // Out-of-range channel selects stay ready so the write is simply dropped.
  always_comb begin
    cfg_ready_o = 1'b1;
    for (int i = 0; i < NUM_CH; i++) begin
      if (cfg_chan_i == CH_W'(i)) cfg_ready_o = ~pend_vec[i];
    end
  end

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    state_e           state_q, state_d;
    logic [CNT_W-1:0] div_q, div_d;
    logic [CNT_W-1:0] pdiv_q, pdiv_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             pend_q, pend_d;
    logic             clk_q, clk_d;
    logic             tick_q, tick_d;
    logic [CNT_W-1:0] eff_div;
    logic [CNT_W:0]   half, cnt_nxt, last;
    logic             wr, apply, start, stop;

    assign wr      = cfg_valid_i && (cfg_chan_i == CH_W'(g)) && !pend_q;
    assign eff_div = pend_q ? pdiv_q : div_q;
    // One extra bit keeps H and D-1 exact at the top of the divisor range.
    assign half    = ({1'b0, div_q} + (CNT_W+1)'(1)) >> 1;
    assign cnt_nxt = {1'b0, cnt_q} + (CNT_W+1)'(1);
    assign last    = {1'b0, div_q} - (CNT_W+1)'(1);

    always_comb begin
      state_d = state_q;
      div_d   = div_q;
      pdiv_d  = pdiv_q;
      pend_d  = pend_q;
      cnt_d   = cnt_q;
      clk_d   = clk_q;
      tick_d  = tick_q;
      apply   = 1'b0;
      start   = 1'b0;
      stop    = 1'b0;

      if (sync_i) begin
        if (en_i[g]) begin
          apply = 1'b1;
          start = (eff_div != '0);
          stop  = (eff_div == '0);
        end else begin
          stop = 1'b1;
        end
      end else if (state_q == IDLE || {1'b0, cnt_q} == last) begin
        apply = 1'b1;
        start = en_i[g] && (eff_div != '0);
        stop  = !start;
      end else begin
        cnt_d  = cnt_nxt[CNT_W-1:0];
        clk_d  = (cnt_nxt < half);
        tick_d = (cnt_nxt == last);
      end

      if (apply) begin
        div_d  = eff_div;
        pend_d = 1'b0;
      end
      if (start) begin
        state_d = RUN;
        cnt_d   = '0;
        clk_d   = 1'b1;
        tick_d  = (eff_div == CNT_W'(1));
      end
      if (stop) begin
        state_d = IDLE;
        cnt_d   = '0;
        clk_d   = 1'b0;
        tick_d  = 1'b0;
      end
      // A write can only be accepted while nothing is pending, so it never races an apply.
      if (wr) begin
        pend_d = 1'b1;
        pdiv_d = cfg_div_i;
      end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
        state_q <= IDLE;
        div_q   <= CNT_W'(DEFAULT_DIV);
        pdiv_q  <= '0;
        pend_q  <= 1'b0;
        cnt_q   <= '0;
        clk_q   <= 1'b0;
        tick_q  <= 1'b0;
      end else begin
        state_q <= state_d;
        div_q   <= div_d;
        pdiv_q  <= pdiv_d;
        pend_q  <= pend_d;
        cnt_q   <= cnt_d;
        clk_q   <= clk_d;
        tick_q  <= tick_d;
      end
    end

    assign clk_o[g]    = clk_q;
    assign tick_o[g]   = tick_q;
    assign pend_vec[g] = pend_q;
  end

endmodule

// File: tb/tb_clk_div_bank.sv
// tb/tb_clk_div_bank.sv - directed vector bench for clk_div_bank
// Waveforms are captured LSB-first, one bit per source cycle after each edge.
module tb_clk_div_bank;

  logic       clk_i;
  logic       rst_i;
  logic [3:0] en_i;
  logic       sync_i;
  logic       cfg_valid_i;
  logic [1:0] cfg_chan_i;
  logic [9:0] cfg_div_i;
  logic       cfg_ready_o;
  logic [3:0] clk_o;
  logic [3:0] tick_o;

  clk_div_bank dut (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .en_i       (en_i),
    .sync_i     (sync_i),
    .cfg_valid_i(cfg_valid_i),
    .cfg_chan_i (cfg_chan_i),
    .cfg_div_i  (cfg_div_i),
    .cfg_ready_o(cfg_ready_o),
    .clk_o      (clk_o),
    .tick_o     (tick_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  int          n_vec = 0;
  int          n_err = 0;
  logic [31:0] cap_c, cap_t, oth;
  int          cap_n;
  logic [7:0]  c0, c1, t0, t1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 'h%0h, expected 'h%0h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk_i);
    #1;
  endtask

  task automatic cap_clear();
    cap_c = '0;
    cap_t = '0;
    cap_n = 0;
  endtask

  task automatic step_cap(input int ch);
    cyc();
    cap_c[cap_n] = clk_o[ch];
    cap_t[cap_n] = tick_o[ch];
    cap_n++;
  endtask

  task automatic do_reset();
    rst_i       = 1'b0;
    en_i        = '0;
    sync_i      = 1'b0;
    cfg_valid_i = 1'b0;
    cfg_chan_i  = '0;
    cfg_div_i   = '0;
    cyc();
    cyc();
    rst_i = 1'b1;
  endtask

  task automatic write_idle(input int ch, input int div);
    cfg_valid_i = 1'b1;
    cfg_chan_i  = 2'(ch);
    cfg_div_i   = 10'(div);
    cyc();
    cfg_valid_i = 1'b0;
  endtask

  initial begin
    // Reset state, then default D=2 on channel 0
    do_reset();
    rst_i = 1'b0;
    cyc();
    check("rst_clk", 32'(clk_o), 32'h0);
    check("rst_tick", 32'(tick_o), 32'h0);
    check("rst_ready", 32'(cfg_ready_o), 32'h1);
    rst_i = 1'b1;
    en_i  = 4'b0001;
    cap_clear();
    oth = '0;
    for (int i = 0; i < 8; i++) begin
      step_cap(0);
      oth = oth | 32'({clk_o[3:1], tick_o[3:1]});
    end
    check("t1_clk0", cap_c, 32'h55);
    check("t1_tick0", cap_t, 32'hAA);
    check("t1_others", oth, 32'h0);

    // D=5 on channel 1
    do_reset();
    cfg_valid_i = 1'b1;
    cfg_chan_i  = 2'd1;
    cfg_div_i   = 10'd5;
    check("t2_ready_idle", 32'(cfg_ready_o), 32'h1);
    cyc();
    cfg_valid_i = 1'b0;
    check("t2_ready_pend", 32'(cfg_ready_o), 32'h0);
    en_i = 4'b0010;
    cap_clear();
    for (int i = 0; i < 10; i++) step_cap(1);
    check("t2_clk1", cap_c, 32'h0E7);
    check("t2_tick1", cap_t, 32'h210);
    check("t2_ready_apply", 32'(cfg_ready_o), 32'h1);

    // D=4 -> 3 change mid-period, second write stalls
    do_reset();
    write_idle(0, 4);
    en_i = 4'b0001;
    cap_clear();
    step_cap(0);
    check("t3_ready_run", 32'(cfg_ready_o), 32'h1);
    step_cap(0);
    cfg_valid_i = 1'b1;
    cfg_chan_i  = 2'd0;
    cfg_div_i   = 10'd3;
    step_cap(0);
    cfg_div_i = 10'd7;
    check("t3_ready_wr", 32'(cfg_ready_o), 32'h0);
    step_cap(0);
    check("t3_stall", 32'(cfg_ready_o), 32'h0);
    cfg_valid_i = 1'b0;
    step_cap(0);
    check("t3_ready_apply", 32'(cfg_ready_o), 32'h1);
    for (int i = 0; i < 6; i++) step_cap(0);
    check("t3_clk0", cap_c, 32'h5B3);
    check("t3_tick0", cap_t, 32'h248);

    // Disable mid-period and D=0 stop on channel 2
    do_reset();
    write_idle(2, 6);
    en_i = 4'b0100;
    cap_clear();
    step_cap(2);
    step_cap(2);
    en_i = 4'b0000;
    for (int i = 0; i < 7; i++) step_cap(2);
    check("t4_dis_clk2", cap_c, 32'h007);
    check("t4_dis_tick2", cap_t, 32'h020);
    en_i = 4'b0100;
    cap_clear();
    step_cap(2);
    cfg_valid_i = 1'b1;
    cfg_chan_i  = 2'd2;
    cfg_div_i   = 10'd0;
    step_cap(2);
    cfg_valid_i = 1'b0;
    for (int i = 0; i < 7; i++) step_cap(2);
    check("t4_stop_clk2", cap_c, 32'h007);
    check("t4_stop_tick2", cap_t, 32'h020);
    check("t4_ready", 32'(cfg_ready_o), 32'h1);

    // Two D=4 channels offset by 2 cycles, realigned by sync
    do_reset();
    write_idle(0, 4);
    write_idle(1, 4);
    en_i = 4'b0001;
    cyc();
    cyc();
    en_i = 4'b0011;
    cyc();
    cyc();
    check("t5_pre_sync", 32'(clk_o[1:0]), 32'h2);
    sync_i = 1'b1;
    for (int i = 0; i < 8; i++) begin
      cyc();
      sync_i = 1'b0;
      c0[i] = clk_o[0];
      c1[i] = clk_o[1];
      t0[i] = tick_o[0];
      t1[i] = tick_o[1];
    end
    check("t5_clk0", 32'(c0), 32'h33);
    check("t5_clk1", 32'(c1), 32'h33);
    check("t5_tick0", 32'(t0), 32'h88);
    check("t5_tick1", 32'(t1), 32'h88);

    // D=1 channel, then async reset mid-high with a pending write
    do_reset();
    write_idle(3, 1);
    write_idle(0, 5);
    en_i = 4'b1001;
    cap_clear();
    for (int i = 0; i < 4; i++) step_cap(3);
    check("t6_clk3", cap_c, 32'hF);
    check("t6_tick3", cap_t, 32'hF);
    cyc();
    cfg_valid_i = 1'b1;
    cfg_chan_i  = 2'd0;
    cfg_div_i   = 10'd7;
    cyc();
    cfg_valid_i = 1'b0;
    check("t6_pre_rst", 32'(clk_o), 32'h9);
    check("t6_pend", 32'(cfg_ready_o), 32'h0);
    #2;
    rst_i = 1'b0;
    #1;
    check("t6_rst_clk", 32'(clk_o), 32'h0);
    check("t6_rst_tick", 32'(tick_o), 32'h0);
    check("t6_rst_ready", 32'(cfg_ready_o), 32'h1);
    en_i = 4'b0000;
    cyc();
    cyc();
    rst_i = 1'b1;
    en_i  = 4'b0001;
    cap_clear();
    for (int i = 0; i < 4; i++) step_cap(0);
    check("t6_def_clk0", cap_c, 32'h5);
    check("t6_def_tick0", cap_t, 32'hA);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
